// File: rtl/mips_rf_pkg.sv
// Shared register-file types and constants for the decoder, hazard unit and the
// multi-port register file.
package mips_rf_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;
  typedef logic [DEFAULT_DEPTH-1:0]  busy_vec_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared by
// writeback, with a registered OR of all bits for pipeline drain.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   any_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             any_busy_q;
  logic             set_ok;

  assign set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == ADDR_W'(REG_ZERO)));

  // Set is applied after clear: a new producer issued in the retiring cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign busy     = busy_q;
  assign any_busy = any_busy_q;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with registered reads, optional hardwired r0
// and pending-write scoreboard. Define REGFILE_BYPASS_EN for write-through reads.
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     any_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .any_busy (any_busy)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : gen_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_d, busy_q;

    always_comb begin
      addr   = rd_addr[g*ADDR_W +: ADDR_W];
      data_d = mem_q[addr];
      busy_d = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // Write-through: the retiring write clears busy, only a same-cycle reissue keeps it.
      if (wr_en && (addr == wr_addr)) begin
        data_d = wr_data;
        busy_d = sb_set && (sb_addr == addr);
      end
`endif
      if ((ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO))) begin
        data_d = '0;
        busy_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (rd_en[g]) begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = data_q;
    assign rd_busy[g]                  = busy_q;
  end

endmodule
